multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-port datapath (PC, IR, register file, ALU, data memory) one instruction at a time.
- Decodes the 4-bit opcode the same way as the combinational decoder: R-type 0-6, BEQ 7, LOAD 9, STORE 10, JUMP 11; 8 and 12-15 are illegal.
- Converts the decoded instruction into per-state enable pulses, handles memory wait states and timeouts, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum cycles spent in IMEM_WAIT or MEM waiting for ready; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enable; sampled only in IDLE and at instruction boundaries.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- alu_zero  in  1  ALU zero flag, valid in EXECUTE.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  IR load pulse.
- pc_inc  out  1  PC+1 pulse.
- pc_load  out  1  PC load from branch/jump target.
- alu_en  out  1  ALU operand/result capture.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier.
- reg_write  out  1  register file write pulse.
- illegal  out  1  one-cycle pulse on an illegal opcode.
- bus_error  out  1  one-cycle pulse on a memory timeout.
- busy  out  1  high in any state except IDLE.
- retired  out  CNT_W  retired legal instruction count.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, retired=0, all outputs 0. Takes effect mid-instruction with no completion of the pending operation.
- State register is clocked; all strobe outputs are decoded combinationally from state and inputs (Moore-plus-ready).
- IDLE: if run=1, go to FETCH.
- FETCH: imem_req=1.
  - imem_ready=1: ir_write=1 and pc_inc=1 in the same cycle, then go to DECODE.
  - imem_ready=0: go to IMEM_WAIT.
- IMEM_WAIT: imem_req held at 1; wait counter increments each cycle.
  - imem_ready=1: ir_write and pc_inc, go to DECODE.
  - Counter reaches MEM_TIMEOUT: bus_error pulse, go to IDLE.
- DECODE: one cycle.
  - Illegal opcode: illegal pulse, no retire, go to FETCH if run=1, else IDLE.
  - Otherwise go to EXECUTE.
- EXECUTE: alu_en=1.
  - R-type: go to WB.
  - BEQ: pc_load=alu_zero; retire; go to boundary.
  - JUMP: pc_load=1; retire; go to boundary.
  - LOAD or STORE: go to MEM.
- MEM: dmem_req=1, dmem_we=1 for STORE only; both held until exit.
  - dmem_ready=1: LOAD goes to WB; STORE retires and goes to boundary.
  - Wait counter reaches MEM_TIMEOUT without ready: bus_error pulse, no retire, go to IDLE.
  - dmem_ready in the same cycle as the timeout: ready wins.
- WB: reg_write=1, retire, go to boundary.
- Boundary: next state is FETCH if run=1, else IDLE. Deasserting run never aborts an instruction in flight.
- Wait counter: clears on entry to IMEM_WAIT/MEM; width ceil(log2(MEM_TIMEOUT+1)).
- Retire: retired increments by 1 in the cycle the instruction completes; wraps from 2^CNT_W-1 to 0.
- Latency with zero-wait memory:
  - R-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BEQ/JUMP: 3 cycles.
- Opcode is sampled in DECODE and held in an internal register; later changes on the opcode pin are ignored.

Decomposition:
- Shared package holds:
  - Opcode localparams: OP_BEQ=7, OP_LOAD=9, OP_STORE=10, OP_JUMP=11, R-type bound 7.
  - State encoding localparams: IDLE, FETCH, IMEM_WAIT, DECODE, EXECUTE, MEM, WB (3-bit).
- One natural sub-module: wait_timer (load/clear, count, expired flag).

Test Plan:
- Reset then run=1, zero-wait memory, opcode=3 -> ir_write/pc_inc cycle 1, alu_en cycle 3, reg_write cycle 4; retired=1.
- LOAD (9) with dmem_ready after 2 wait cycles -> dmem_req high 3 cycles, dmem_we=0, reg_write one cycle later; retired increments once.
- BEQ (7) with alu_zero=1, then alu_zero=0 -> pc_load 1 then 0; retired +1 each; no reg_write.
- Opcode 13 -> illegal pulse in DECODE, retired unchanged, next FETCH follows.
- STORE with dmem_ready never asserted, MEM_TIMEOUT=4 -> dmem_req/dmem_we held 4 cycles, bus_error pulse, state IDLE, retired unchanged.
- run dropped during EXECUTE of JUMP -> instruction completes (pc_load), then IDLE; separately, rst_n low mid-MEM -> all outputs 0 immediately, retired=0.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared opcode, state and instruction-class definitions
// for the multi-cycle control sequencer.
package multicycle_sequencer_pkg;

   localparam logic [3:0] OP_R_BOUND = 4'd7;
   localparam logic [3:0] OP_BEQ     = 4'd7;
   localparam logic [3:0] OP_LOAD    = 4'd9;
   localparam logic [3:0] OP_STORE   = 4'd10;
   localparam logic [3:0] OP_JUMP    = 4'd11;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_IMEM_WAIT = 3'd2,
      S_DECODE    = 3'd3,
      S_EXECUTE   = 3'd4,
      S_MEM       = 3'd5,
      S_WB        = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      C_RTYPE   = 3'd0,
      C_BEQ     = 3'd1,
      C_LOAD    = 3'd2,
      C_STORE   = 3'd3,
      C_JUMP    = 3'd4,
      C_ILLEGAL = 3'd5
   } op_class_e;

   function automatic op_class_e classify(input logic [3:0] op);
      op_class_e c;
      c = C_ILLEGAL;
      if (op < OP_R_BOUND) c = C_RTYPE;
      else if (op == OP_BEQ) c = C_BEQ;
      else if (op == OP_LOAD) c = C_LOAD;
      else if (op == OP_STORE) c = C_STORE;
      else if (op == OP_JUMP) c = C_JUMP;
      return c;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Memory wait-state timer: cleared outside wait states,
// flags the last permitted wait cycle.
module multicycle_sequencer_wait_timer #(
   parameter int LIMIT = 15,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) cnt_d = '0;
      else if (en) cnt_d = cnt_q + W'(1);
   end

   // the current cycle is the LIMIT-th cycle spent waiting
   assign expired = en && (cnt_q == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sequencing fetch, decode, execute,
// memory and write-back for one instruction at a time.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic             alu_zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             alu_en,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_write,
   output logic             illegal,
   output logic             bus_error,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   state_e           state_q;
   state_e           state_d;
   op_class_e        class_q;
   op_class_e        class_d;
   op_class_e        dec_class;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] retired_d;
   logic             retire;
   logic             waiting;
   logic             expired;

   assign waiting = (state_q == S_IMEM_WAIT) || (state_q == S_MEM);

   multicycle_sequencer_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!waiting),
      .en      (waiting),
      .expired (expired)
   );

   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      retired_d = retired_q;
      dec_class = classify(opcode);
      retire    = 1'b0;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      alu_en    = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      bus_error = 1'b0;
      busy      = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH, S_IMEM_WAIT: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_inc   = 1'b1;
               state_d  = S_DECODE;
            end else if (state_q == S_FETCH) begin
               state_d = S_IMEM_WAIT;
            end else if (expired) begin
               bus_error = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_DECODE: begin
            class_d = dec_class;
            if (dec_class == C_ILLEGAL) begin
               illegal = 1'b1;
               state_d = run ? S_FETCH : S_IDLE;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_en = 1'b1;
            unique case (class_q)
               C_RTYPE: state_d = S_WB;
               C_BEQ: begin
                  pc_load = alu_zero;
                  retire  = 1'b1;
               end
               C_JUMP: begin
                  pc_load = 1'b1;
                  retire  = 1'b1;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default: state_d = S_IDLE;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (class_q == C_STORE);
            // ready takes priority over a coincident timeout
            if (dmem_ready) begin
               if (class_q == C_STORE) retire = 1'b1;
               else state_d = S_WB;
            end else if (expired) begin
               bus_error = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (retire) begin
         retired_d = retired_q + CNT_W'(1);
         state_d   = run ? S_FETCH : S_IDLE;
      end
   end

   assign retired = retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         class_q   <= C_RTYPE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         retired_q <= retired_d;
      end
   end

endmodule
